// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter for CP0: syncs interrupt lines, picks the
// MEM-stage exception code and sequences the flush/drain redirect.
module exc_arbiter #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          SYNC_STAGES  = 2,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int_i,
  input  logic        timer_int_i,
  output logic [5:0]  cp0_int_o,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_dslot_i,
  input  logic [4:0]  mem_exc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_dslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        hold_o
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] new_pc_d;
  logic [SYNC_STAGES-1:0][5:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ext_int_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign cp0_int_o = sync_q[SYNC_STAGES-1] | {timer_int_i, 5'b0};

  // WB bypass: a CP0 write retiring this cycle is not yet visible in the regs
  logic wr_st, wr_cs, wr_epc;
  logic [31:0] st, cs, epc;
  logic int_pend;
  logic unused_bits;

  assign wr_st  = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd12);
  assign wr_cs  = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd13);
  assign wr_epc = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd14);

  assign st  = wr_st  ? wb_cp0_data_i : status_i;
  assign epc = wr_epc ? wb_cp0_data_i : epc_i;
  assign cs  = wr_cs ? {cause_i[31:10], wb_cp0_data_i[9:8], cause_i[7:0]}
                     : cause_i;

  assign int_pend = (|(cs[15:8] & st[15:8])) && !st[1] && st[0];
  assign unused_bits = ^{st[31:16], st[7:2], cs[31:16], cs[7:0]};

  logic [4:0] code;

  always_comb begin
    code = 5'h00;
    if (!rst && state_q == IDLE && mem_valid_i) begin
      priority case (1'b1)
        int_pend:     code = 5'h01;
        mem_exc_i[0]: code = 5'h0a;
        mem_exc_i[1]: code = 5'h08;
        mem_exc_i[2]: code = 5'h0d;
        mem_exc_i[3]: code = 5'h0c;
        mem_exc_i[4]: code = 5'h0e;
        default:      code = 5'h00;
      endcase
    end
  end

  assign excepttype_o = {27'b0, code};
  assign exc_pc_o     = mem_pc_i;
  assign exc_dslot_o  = mem_dslot_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      new_pc_o <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_o <= new_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_o;
    unique case (state_q)
      IDLE: begin
        if (code != 5'h00) begin
          state_d  = FLUSH;
          new_pc_d = (code == 5'h0e) ? epc : EXC_VECTOR;
        end
      end
      FLUSH: begin
        cnt_d   = CW'(DRAIN_CYCLES);
        state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_o = (state_q == FLUSH);
  assign hold_o  = (state_q == DRAIN);

endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: directed scenarios plus a randomized run
// against a cycle-number-based reference model.
module tb_exc_arbiter;

  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int SYNC = 2;
  localparam int D    = 2;

  logic        clk = 0;
  logic        rst;
  logic [5:0]  ext_int;
  logic        timer;
  logic [5:0]  cp0_int;
  logic [31:0] status, cause, epc;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_dslot;
  logic [4:0]  mem_exc;
  logic [31:0] exc_type, exc_pc, new_pc;
  logic        exc_dslot, flush, hold;

  int total = 0;
  int bad   = 0;

  exc_arbiter #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .ext_int_i(ext_int), .timer_int_i(timer), .cp0_int_o(cp0_int),
    .status_i(status), .cause_i(cause), .epc_i(epc),
    .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr),
    .wb_cp0_data_i(wb_data),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc),
    .mem_dslot_i(mem_dslot), .mem_exc_i(mem_exc),
    .excepttype_o(exc_type), .exc_pc_o(exc_pc),
    .exc_dslot_o(exc_dslot), .flush_o(flush),
    .new_pc_o(new_pc), .hold_o(hold)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ext_int = 0; timer = 0; status = 0; cause = 0; epc = 0;
    wb_we = 0; wb_waddr = 0; wb_data = 0;
    mem_valid = 0; mem_pc = 0; mem_dslot = 0; mem_exc = 0;
  endtask

  task automatic settle();
    clear_in();
    repeat (6) tick();
  endtask

  // Reference: exception code straight from the architectural rules
  function automatic logic [31:0] ref_code();
    logic [31:0] s, c;
    bit pend;
    s = (wb_we && wb_waddr == 12) ? wb_data : status;
    c = cause;
    if (wb_we && wb_waddr == 13) begin
      c[8] = wb_data[8];
      c[9] = wb_data[9];
    end
    pend = ((c[15:8] & s[15:8]) != 0) && !s[1] && s[0];
    if (pend)            return 32'h01;
    else if (mem_exc[0]) return 32'h0a;
    else if (mem_exc[1]) return 32'h08;
    else if (mem_exc[2]) return 32'h0d;
    else if (mem_exc[3]) return 32'h0c;
    else if (mem_exc[4]) return 32'h0e;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_epc();
    return (wb_we && wb_waddr == 14) ? wb_data : epc;
  endfunction

  task automatic test_reset();
    clear_in();
    rst = 1;
    mem_valid = 1; mem_exc = 5'b00010; status = 32'h1000_0001;
    repeat (3) tick();
    @(negedge clk);
    total++; if (flush !== 1'b0) begin bad++;
      $display("FAIL reset_flush got=%b want=0", flush); end
    total++; if (hold !== 1'b0) begin bad++;
      $display("FAIL reset_hold got=%b want=0", hold); end
    total++; if (cp0_int !== 6'b0) begin bad++;
      $display("FAIL reset_cp0_int got=%b want=0", cp0_int); end
    total++; if (exc_type !== 32'h0) begin bad++;
      $display("FAIL reset_exc got=%h want=0", exc_type); end
    tick();
    rst = 0;
    clear_in();
    tick();
  endtask

  task automatic test_sync();
    ext_int = 6'b000100;
    for (int k = 1; k <= SYNC; k++) begin
      tick();
      @(negedge clk);
      total++;
      if (cp0_int[2] !== (k == SYNC)) begin bad++;
        $display("FAIL sync_lat k=%0d got=%b want=%b",
                 k, cp0_int[2], (k == SYNC)); end
    end
    tick();
    timer = 1;
    #1;
    total++; if (cp0_int !== 6'b100100) begin bad++;
      $display("FAIL sync_timer got=%b want=100100", cp0_int); end
    timer = 0;
    #1;
    total++; if (cp0_int[5] !== 1'b0) begin bad++;
      $display("FAIL sync_timer_off got=%b want=0", cp0_int[5]); end
    settle();
  endtask

  task automatic test_syscall();
    mem_valid = 1; mem_pc = 32'h100; mem_dslot = 1;
    status = 32'h1000_0001; mem_exc = 5'b00010;
    @(negedge clk);
    total++; if (exc_type !== 32'h08) begin bad++;
      $display("FAIL sys_code got=%h want=08", exc_type); end
    total++; if (exc_pc !== 32'h100 || exc_dslot !== 1'b1) begin bad++;
      $display("FAIL sys_pass got=%h/%b want=100/1", exc_pc, exc_dslot); end
    tick();
    @(negedge clk);
    total++;
    if (flush !== 1'b1 || new_pc !== VEC || exc_type !== 0 || hold !== 0)
    begin bad++;
      $display("FAIL sys_flush got=%b/%h/%h/%b want=1/20/0/0",
               flush, new_pc, exc_type, hold); end
    for (int k = 0; k < D; k++) begin
      tick();
      @(negedge clk);
      total++;
      if (hold !== 1'b1 || flush !== 1'b0 || exc_type !== 0) begin bad++;
        $display("FAIL sys_hold k=%0d got=%b/%b/%h want=1/0/0",
                 k, hold, flush, exc_type); end
    end
    tick();
    @(negedge clk);
    total++; if (hold !== 1'b0 || exc_type !== 32'h08) begin bad++;
      $display("FAIL sys_rearm got=%b/%h want=0/08", hold, exc_type); end
    settle();
  endtask

  task automatic test_eret();
    mem_valid = 1; mem_pc = 32'h104; status = 32'h1000_0001;
    mem_exc = 5'b10000; epc = 32'h40;
    wb_we = 1; wb_waddr = 14; wb_data = 32'h80;
    @(negedge clk);
    total++; if (exc_type !== 32'h0e) begin bad++;
      $display("FAIL eret_code got=%h want=0e", exc_type); end
    tick();
    wb_we = 0;
    @(negedge clk);
    total++; if (flush !== 1'b1 || new_pc !== 32'h80) begin bad++;
      $display("FAIL eret_pc got=%b/%h want=1/80", flush, new_pc); end
    settle();
  endtask

  task automatic test_priority();
    mem_valid = 1; cause = 32'h400; status = 32'h1000_0401;
    mem_exc = 5'b01001;
    @(negedge clk);
    total++; if (exc_type !== 32'h01) begin bad++;
      $display("FAIL prio_int got=%h want=01", exc_type); end
    settle();
    mem_valid = 1; cause = 32'h400; status = 32'h1000_0403;
    mem_exc = 5'b01001;
    @(negedge clk);
    total++; if (exc_type !== 32'h0a) begin bad++;
      $display("FAIL prio_exl got=%h want=0a", exc_type); end
    settle();
    mem_valid = 1; cause = 32'h400; status = 32'h1000_0401;
    mem_exc = 5'b10000;
    @(negedge clk);
    total++; if (exc_type !== 32'h01) begin bad++;
      $display("FAIL prio_eret got=%h want=01", exc_type); end
    settle();
    mem_valid = 1; cause = 32'h400; status = 32'h1000_0401;
    wb_we = 1; wb_waddr = 12; wb_data = 32'h1000_0400;
    @(negedge clk);
    total++; if (exc_type !== 32'h0) begin bad++;
      $display("FAIL prio_ie_byp got=%h want=0", exc_type); end
    tick();
    @(negedge clk);
    total++; if (flush !== 1'b0) begin bad++;
      $display("FAIL prio_ie_flush got=%b want=0", flush); end
    settle();
    mem_valid = 1; cause = 32'h0; status = 32'h1000_0101;
    wb_we = 1; wb_waddr = 13; wb_data = 32'h100;
    @(negedge clk);
    total++; if (exc_type !== 32'h01) begin bad++;
      $display("FAIL prio_cause_byp got=%h want=01", exc_type); end
    settle();
  endtask

  task automatic test_pending_rst();
    cause = 32'h400; status = 32'h1000_0401; mem_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (exc_type !== 0 || flush !== 0) begin bad++;
        $display("FAIL pend_idle k=%0d got=%h/%b want=0/0",
                 k, exc_type, flush); end
      tick();
    end
    mem_valid = 1; mem_pc = 32'h200;
    @(negedge clk);
    total++; if (exc_type !== 32'h01) begin bad++;
      $display("FAIL pend_take got=%h want=01", exc_type); end
    tick();
    mem_valid = 0;
    @(negedge clk);
    total++; if (flush !== 1'b1 || new_pc !== VEC) begin bad++;
      $display("FAIL pend_flush got=%b/%h want=1/20", flush, new_pc); end
    tick();
    @(negedge clk);
    total++; if (hold !== 1'b1) begin bad++;
      $display("FAIL pend_drain got=%b want=1", hold); end
    rst = 1;
    tick();
    @(negedge clk);
    total++;
    if (hold !== 0 || flush !== 0 || new_pc !== 0 || exc_type !== 0)
    begin bad++;
      $display("FAIL drain_rst got=%b/%b/%h/%h want=0/0/0/0",
               hold, flush, new_pc, exc_type); end
    tick();
    rst = 0;
    settle();
  endtask

  task automatic test_random();
    int t_det = -100;
    int free_at = 0;
    logic [31:0] tgt = 0;
    logic [31:0] code, e_exc;
    bit idle, e_flush, e_hold;
    for (int cyc = 0; cyc < 400; cyc++) begin
      mem_valid = ($urandom % 4) != 0;
      mem_pc    = $urandom;
      mem_dslot = $urandom % 2;
      mem_exc   = (($urandom % 3) == 0) ? 5'($urandom) : 5'b0;
      cause     = (($urandom % 4) == 0) ? 32'($urandom) : 32'h0;
      status    = $urandom;
      status[0] = ($urandom % 4) != 0;
      status[1] = ($urandom % 4) == 0;
      epc       = $urandom;
      wb_we     = ($urandom % 3) == 0;
      wb_waddr  = 5'($urandom_range(11, 15));
      wb_data   = $urandom;
      @(negedge clk);
      idle    = cyc >= free_at;
      code    = ref_code();
      e_exc   = (idle && mem_valid) ? code : 32'h0;
      e_flush = (cyc == t_det + 1);
      e_hold  = (cyc >= t_det + 2) && (cyc <= t_det + 1 + D);
      total++; if (exc_type !== e_exc) begin bad++;
        $display("FAIL rnd_exc c=%0d got=%h want=%h", cyc, exc_type, e_exc); end
      total++; if (flush !== e_flush) begin bad++;
        $display("FAIL rnd_flush c=%0d got=%b want=%b", cyc, flush, e_flush); end
      total++; if (hold !== e_hold) begin bad++;
        $display("FAIL rnd_hold c=%0d got=%b want=%b", cyc, hold, e_hold); end
      total++; if (exc_pc !== mem_pc || exc_dslot !== mem_dslot) begin bad++;
        $display("FAIL rnd_pass c=%0d got=%h want=%h", cyc, exc_pc, mem_pc); end
      if (e_flush) begin
        total++; if (new_pc !== tgt) begin bad++;
          $display("FAIL rnd_newpc c=%0d got=%h want=%h", cyc, new_pc, tgt); end
      end
      if (e_exc != 0) begin
        t_det   = cyc;
        free_at = cyc + 2 + D;
        tgt     = (e_exc == 32'h0e) ? ref_epc() : VEC;
      end
      tick();
    end
    settle();
  endtask

  initial begin
    rst = 1;
    clear_in();
    test_reset();
    test_sync();
    test_syscall();
    test_eret();
    test_priority();
    test_pending_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
